// File: rtl/ks_pkg.sv
// Shared Kogge-Stone adder types: default width, skid-stage state, result bundle.
// No ports; imported by the interface, layer_sum and the top-level adder.
package ks_pkg;

  localparam int KS_W = 16;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_TWO
  } state_t;

  typedef struct packed {
    logic [KS_W-1:0] sum;
    logic            cout;
    logic            ovf;
  } res_t;

endpackage

// File: rtl/layer_sum_if.sv
// Handshake bundle for layer_sum: operand side (in_*) and result side (out_*).
// master = producer/consumer pair (bench or neighbours), slave = the stage.
interface layer_sum_if
  import ks_pkg::*;
#(
  parameter int W = KS_W
);

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] P_IN;
  logic [W-1:0] G_IN;
  logic         CIN;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] SUM;
  logic         COUT;
  logic         OVF;

  modport master (
    output in_valid,
    output P_IN,
    output G_IN,
    output CIN,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  SUM,
    input  COUT,
    input  OVF
  );

  modport slave (
    input  in_valid,
    input  P_IN,
    input  G_IN,
    input  CIN,
    input  out_ready,
    output in_ready,
    output out_valid,
    output SUM,
    output COUT,
    output OVF
  );

endinterface

// File: rtl/sum_gen.sv
// Per-bit sum cell: s = p ^ c.
// Ports: p (bit propagate), c (carry into the bit), s (sum bit).
module sum_gen (
  input  logic p,
  input  logic c,
  output logic s
);

  assign s = p ^ c;

endmodule

// File: rtl/layer_sum.sv
// Kogge-Stone final layer: SUM/COUT/OVF from P and prefix G, skid-buffered.
// Ports: clk, rst_n (async, active-low), bus (layer_sum_if.slave).
module layer_sum
  import ks_pkg::*;
#(
  parameter int W = KS_W
) (
  input  logic        clk,
  input  logic        rst_n,
  layer_sum_if.slave  bus
);

  logic [W-1:0] carry;
  logic [W-1:0] s;
  res_t         calc;

  // G_IN is prefix-complete, so the carry into bit i is just G_IN[i-1].
  assign carry = {bus.G_IN[W-2:0], bus.CIN};

  for (genvar i = 0; i < W; i++) begin : g_bit
    sum_gen u_sum (
      .p (bus.P_IN[i]),
      .c (carry[i]),
      .s (s[i])
    );
  end

  always_comb begin
    calc      = '0;
    calc.sum  = s;
    calc.cout = bus.G_IN[W-1];
    calc.ovf  = bus.G_IN[W-1] ^ bus.G_IN[W-2];
  end

  state_t state;
  state_t state_n;
  res_t   main_q;
  res_t   skid_q;
  logic   accept;
  logic   take;
  logic   load_main;
  logic   load_skid;
  logic   skid_to_main;

  // Both handshake outputs decode the state register only.
  assign bus.in_ready  = (state != ST_TWO);
  assign bus.out_valid = (state != ST_EMPTY);

  assign accept = bus.in_valid & bus.in_ready;
  assign take   = bus.out_valid & bus.out_ready;

  always_comb begin
    state_n      = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          state_n   = ST_ONE;
        end
      end
      ST_ONE: begin
        unique case (1'b1)
          accept & take: begin
            load_main = 1'b1;
          end
          accept & ~take: begin
            load_skid = 1'b1;
            state_n   = ST_TWO;
          end
          ~accept & take: begin
            state_n = ST_EMPTY;
          end
          default: begin
            state_n = ST_ONE;
          end
        endcase
      end
      ST_TWO: begin
        if (take) begin
          skid_to_main = 1'b1;
          state_n      = ST_ONE;
        end
      end
      default: begin
        state_n = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= calc;
      end else if (skid_to_main) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= calc;
      end
    end
  end

  assign bus.SUM  = main_q.sum;
  assign bus.COUT = main_q.cout;
  assign bus.OVF  = main_q.ovf;

endmodule

// File: tb/tb_layer_sum.sv
// Directed and streaming bench for layer_sum.
// Drives at negedge, samples at negedge; model is a ripple A+B+CIN.
module tb_layer_sum;
  import ks_pkg::*;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  layer_sum_if #(.W(16)) bus ();

  layer_sum #(.W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] gen_g(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        c
  );
    logic [15:0] g;
    logic        cy;
    cy = c;
    for (int i = 0; i < 16; i++) begin
      cy   = (a[i] & b[i]) | ((a[i] ^ b[i]) & cy);
      g[i] = cy;
    end
    return g;
  endfunction

  // Expected {sum, cout, ovf} from plain integer addition.
  function automatic logic [17:0] ref_res(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        c
  );
    logic [16:0] t;
    logic        v;
    t = {1'b0, a} + {1'b0, b} + {16'd0, c};
    v = (a[15] == b[15]) && (t[15] != a[15]);
    return {t[15:0], t[16], v};
  endfunction

  task automatic drive_ab(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        c
  );
    bus.P_IN = a ^ b;
    bus.G_IN = gen_g(a, b, c);
    bus.CIN  = c;
  endtask

  task automatic test_reset;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.P_IN      = '0;
    bus.G_IN      = '0;
    bus.CIN       = 1'b0;
    #3;
    n_total++;
    if ({bus.out_valid, bus.in_ready, bus.SUM, bus.COUT, bus.OVF}
        !== {1'b0, 1'b1, 16'h0, 1'b0, 1'b0})
      $display("FAIL reset: v=%b r=%b s=%h c=%b o=%b want 0 1 0000 0 0",
               bus.out_valid, bus.in_ready, bus.SUM, bus.COUT, bus.OVF);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single(
    input string       name,
    input logic [15:0] p,
    input logic [15:0] g,
    input logic        c,
    input logic [15:0] e_sum,
    input logic        e_cout,
    input logic        e_ovf
  );
    @(negedge clk);
    bus.P_IN      = p;
    bus.G_IN      = g;
    bus.CIN       = c;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_total++;
    if ({bus.out_valid, bus.SUM, bus.COUT, bus.OVF}
        !== {1'b1, e_sum, e_cout, e_ovf})
      $display("FAIL %s: v=%b s=%h c=%b o=%b want 1 %h %b %b", name,
               bus.out_valid, bus.SUM, bus.COUT, bus.OVF,
               e_sum, e_cout, e_ovf);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL %s_drain: out_valid=%b want 0", name, bus.out_valid);
    else n_pass++;
  endtask

  task automatic chk_bp(
    input string       name,
    input logic        e_rdy,
    input logic        e_vld,
    input logic [15:0] e_sum
  );
    n_total++;
    if ({bus.in_ready, bus.out_valid, bus.SUM} !== {e_rdy, e_vld, e_sum})
      $display("FAIL %s: rdy=%b v=%b s=%h want %b %b %h", name,
               bus.in_ready, bus.out_valid, bus.SUM, e_rdy, e_vld, e_sum);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive_ab(16'd1, 16'd2, 1'b0);
    @(negedge clk);
    chk_bp("bp_one", 1'b1, 1'b1, 16'd3);
    drive_ab(16'd3, 16'd4, 1'b0);
    @(negedge clk);
    chk_bp("bp_two", 1'b0, 1'b1, 16'd3);
    drive_ab(16'd5, 16'd6, 1'b0);
    @(negedge clk);
    chk_bp("bp_hold", 1'b0, 1'b1, 16'd3);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk_bp("bp_drain1", 1'b1, 1'b1, 16'd7);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_bp("bp_drain2", 1'b1, 1'b1, 16'd11);
    @(negedge clk);
    chk_bp("bp_empty", 1'b1, 1'b0, 16'd11);
  endtask

  task automatic test_streaming;
    logic [17:0] q[$];
    logic [17:0] exp_r;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    int          sent;
    int          got;
    int          cyc;
    sent = 0;
    got  = 0;
    cyc  = 0;
    a = 16'($urandom);
    b = 16'($urandom);
    c = 1'($urandom);
    while (got < 100 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      bus.in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      drive_ab(a, b, c);
      if (bus.out_valid && bus.out_ready) begin
        exp_r = q.pop_front();
        got++;
        n_total++;
        if ({bus.SUM, bus.COUT, bus.OVF} !== exp_r)
          $display("FAIL stream[%0d]: got %h %b %b want %h %b %b", got,
                   bus.SUM, bus.COUT, bus.OVF,
                   exp_r[17:2], exp_r[1], exp_r[0]);
        else n_pass++;
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(ref_res(a, b, c));
        sent++;
        a = 16'($urandom);
        b = 16'($urandom);
        c = 1'($urandom);
      end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n_total++;
    if (got != 100)
      $display("FAIL stream_count: got %0d results want 100", got);
    else n_pass++;
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive_ab(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    drive_ab(16'h0100, 16'h0200, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_bp("ar_in_two", 1'b0, 1'b1, 16'h3333);
    #2;
    rst_n = 1'b0;
    #1;
    chk_bp("ar_immediate", 1'b1, 1'b0, 16'h0000);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    drive_ab(16'h00F0, 16'h000F, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_bp("ar_first", 1'b1, 1'b1, 16'h0100);
    @(negedge clk);
    chk_bp("ar_after", 1'b1, 1'b0, 16'h0100);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_single("max_plus_one", 16'hFFFE, 16'hFFFF, 1'b0,
                16'h0000, 1'b1, 1'b0);
    test_single("signed_ovf", 16'h7FFE, 16'h7FFF, 1'b0,
                16'h8000, 1'b0, 1'b1);
    test_single("cin_only", 16'h0000, 16'h0000, 1'b1,
                16'h0001, 1'b0, 1'b0);
    test_backpressure();
    test_streaming();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
